// File: rtl/apb_cmd_master_if.sv
// Command/response and APB requester signal bundle for apb_cmd_master.
// The master modport is the block's view; slave is the command source plus APB completer.
interface apb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata,
        input  busy
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding command to APB requester with wait-state timeout abort.
// Latency: accept, SETUP, ACCESS (+waits), RESP; no new command until the response handshake.
module apb_cmd_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_cmd_master_if.master bus
);

    localparam int unsigned    CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0]  TO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_to_q, rsp_to_d;
    logic [CW-1:0]   wait_q, wait_d;

    logic            accept;
    logic            complete;
    logic            abort;

    assign accept   = (state_q == IDLE) && bus.cmd_valid;
    assign complete = (state_q == ACCESS) && bus.pready;
    // pready wins over an expiring counter on the same cycle
    assign abort    = TO_EN && (state_q == ACCESS) && !bus.pready && (wait_q == TO_LAST);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (complete || abort) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == IDLE);
        bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
        bus.penable   = (state_q == ACCESS);
        bus.rsp_valid = (state_q == RESP);
        bus.busy      = (state_q != IDLE);
    end

    always_comb begin
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        wait_d      = wait_q;

        if (accept) begin
            wr_d    = bus.cmd_write;
            addr_d  = bus.cmd_addr;
            wdata_d = bus.cmd_wdata;
        end

        if (state_q == SETUP) begin
            wait_d = '0;
        end else if ((state_q == ACCESS) && !bus.pready && (wait_q != TO_MAX)) begin
            wait_d = wait_q + 1'b1;
        end

        if (complete) begin
            rsp_rdata_d = wr_q ? 32'h0 : bus.prdata;
            rsp_err_d   = bus.pslverr;
            rsp_to_d    = 1'b0;
        end else if (abort) begin
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            wait_q      <= '0;
        end else begin
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            wait_q      <= wait_d;
        end
    end

    assign bus.pwrite      = wr_q;
    assign bus.paddr       = addr_q;
    assign bus.pwdata      = wdata_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_to_q;

endmodule
